// File: rtl/gate_cosim_pkg.sv
// -----------------------------------------------------------------------------
// gate_cosim_pkg
// Shared types and constants for the gate cosimulation sequencer.
//   state_e        : sequencer FSM states
//   SETTLE_W       : width of the settle-window down-counter
//   DEFAULT_WIDTH  : default spec input/output width
//   DEFAULT_CNT_W  : default vector/error counter width
// -----------------------------------------------------------------------------
package gate_cosim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SETTLE,
        ST_CAPTURE,
        ST_REPORT,
        ST_DONE
    } state_e;

    localparam int SETTLE_W      = 4;
    localparam int DEFAULT_WIDTH = 128;
    localparam int DEFAULT_CNT_W = 16;

endpackage

// File: rtl/gate_cosim_cmp.sv
// -----------------------------------------------------------------------------
// gate_cosim_cmp
// Masked comparison of the captured spec output against the expected word.
//   out_word   : spec module output
//   exp_word   : expected output
//   mask_word  : 1 = compare this bit, 0 = don't care
//   mismatch   : high when any compared bit differs
// -----------------------------------------------------------------------------
module gate_cosim_cmp #(
    parameter int WIDTH = 128
) (
    input  logic [WIDTH-1:0] out_word,
    input  logic [WIDTH-1:0] exp_word,
    input  logic [WIDTH-1:0] mask_word,
    output logic             mismatch
);

    assign mismatch = |((out_word ^ exp_word) & mask_word);

endmodule

// File: rtl/gate_cosim_sequencer.sv
// -----------------------------------------------------------------------------
// gate_cosim_sequencer
// Feeds stimulus vectors into a combinational spec module, holds each one for
// a settle window, captures and mask-compares the output, and reports the
// result through a valid/ready handshake. Counts mismatches and results.
//   clk, rst                : clock, synchronous active-high reset
//   start, num_vecs         : begin a run of num_vecs vectors (IDLE/DONE only)
//   vec_valid/vec_ready     : stimulus handshake (vec_stim, vec_exp, vec_mask)
//   dut_in, dut_out         : spec module input / output
//   res_valid/res_ready     : result handshake (res_data, res_mismatch)
//   err_count, vec_count    : mismatches (saturating) / results consumed
//   busy, done              : run in progress / run finished
// SETTLE must lie in 1..15 to fit the settle counter.
// -----------------------------------------------------------------------------
module gate_cosim_sequencer
    import gate_cosim_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int CNT_W  = DEFAULT_CNT_W,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vecs,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [WIDTH-1:0] vec_stim,
    input  logic [WIDTH-1:0] vec_exp,
    input  logic [WIDTH-1:0] vec_mask,
    output logic [WIDTH-1:0] dut_in,
    input  logic [WIDTH-1:0] dut_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_mismatch,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] vec_count,
    output logic             busy,
    output logic             done
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic [WIDTH-1:0]    exp_q, exp_d;
    logic [WIDTH-1:0]    mask_q, mask_d;
    logic [WIDTH-1:0]    dut_in_q, dut_in_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]    res_data_q, res_data_d;
    logic                res_mm_q, res_mm_d;
    logic [CNT_W-1:0]    err_q, err_d;
    logic [CNT_W-1:0]    vec_q, vec_d;
    logic                vec_ready_q, vec_ready_d;
    logic                res_valid_q, res_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                cmp_mismatch;
    logic [CNT_W-1:0]    vec_inc;

    gate_cosim_cmp #(.WIDTH(WIDTH)) u_cmp (
        .out_word  (dut_out),
        .exp_word  (exp_q),
        .mask_word (mask_q),
        .mismatch  (cmp_mismatch)
    );

    always_comb begin
        // NOTE: every _d takes its held value first so no latch is inferred.
        state_d    = state_q;
        num_d      = num_q;
        exp_d      = exp_q;
        mask_d     = mask_q;
        dut_in_d   = dut_in_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        res_mm_d   = res_mm_q;
        err_d      = err_q;
        vec_d      = vec_q;
        vec_inc    = vec_q + CNT_W'(1);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    num_d   = num_vecs;
                    err_d   = '0;
                    vec_d   = '0;
                    state_d = (num_vecs == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (vec_valid && vec_ready_q) begin
                    exp_d    = vec_exp;
                    mask_d   = vec_mask;
                    dut_in_d = vec_stim;
                    cnt_d    = SETTLE_W'(SETTLE - 1);
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // Counter starts at SETTLE-1, so this state lasts SETTLE cycles.
                if (cnt_q == '0) state_d = ST_CAPTURE;
                else             cnt_d   = cnt_q - SETTLE_W'(1);
            end
            ST_CAPTURE: begin
                res_data_d = dut_out;
                res_mm_d   = cmp_mismatch;
                if (cmp_mismatch && (err_q != '1)) err_d = err_q + CNT_W'(1);
                state_d = ST_REPORT;
            end
            ST_REPORT: begin
                if (res_ready) begin
                    vec_d   = vec_inc;
                    state_d = (vec_inc == num_q) ? ST_DONE : ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state they describe.
        vec_ready_d = (state_d == ST_FETCH);
        res_valid_d = (state_d == ST_REPORT);
        busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            // NOTE: datapath words are reset as well, since dut_in and
            // res_data must read 0 after reset.
            state_q     <= ST_IDLE;
            num_q       <= '0;
            exp_q       <= '0;
            mask_q      <= '0;
            dut_in_q    <= '0;
            cnt_q       <= '0;
            res_data_q  <= '0;
            res_mm_q    <= 1'b0;
            err_q       <= '0;
            vec_q       <= '0;
            vec_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            exp_q       <= exp_d;
            mask_q      <= mask_d;
            dut_in_q    <= dut_in_d;
            cnt_q       <= cnt_d;
            res_data_q  <= res_data_d;
            res_mm_q    <= res_mm_d;
            err_q       <= err_d;
            vec_q       <= vec_d;
            vec_ready_q <= vec_ready_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign vec_ready    = vec_ready_q;
    assign dut_in       = dut_in_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_mismatch = res_mm_q;
    assign err_count    = err_q;
    assign vec_count    = vec_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
